ram_loader: RTL and testbench
=============================

RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 SHALL: clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL: clr  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: start  input  1  request a load session; sampled only in IDLE.
REQ-004 SHALL: abort  input  1  terminate session immediately; no done pulse.
REQ-005 SHALL: rx_data  input  8  incoming program byte.
REQ-006 SHALL: rx_valid  input  1  rx_data valid.
REQ-007 SHALL: rx_ready  output  1  loader accepts byte; transfer = rx_valid & rx_ready on a clk edge.
REQ-008 SHALL: program  output  1  drives RAM program-mode select.
REQ-009 SHALL: manual_addr  output  4  RAM write address in program mode.
REQ-010 SHALL: manual_data_in  output  8  RAM write data in program mode.
REQ-011 SHALL: manual_clk  output  1  RAM write strobe, registered, glitch-free.
REQ-012 SHALL: busy  output  1  high in every state except IDLE.
REQ-013 SHALL: done  output  1  one-cycle pulse at successful session end.
REQ-014 SHALL: error  output  1  checksum mismatch flag (see Configuration).

Function
REQ-015 SHALL: states IDLE, WAIT_BYTE, SETUP, STROBE, HOLD, CHECK, DONE; all outputs registered.
REQ-016 SHALL: IDLE + start=1 -> WAIT_BYTE; manual_addr=0, program=1, error cleared.
REQ-017 SHALL: rx_ready=1 only in WAIT_BYTE; transfer latches rx_data into manual_data_in, -> SETUP.
REQ-018 SHALL: SETUP: manual_clk=0, one cycle -> STROBE.
REQ-019 SHALL: STROBE: manual_clk=1, one cycle -> HOLD; data/address stable across the rising strobe.
REQ-020 SHALL: HOLD: manual_clk=0, one cycle; manual_addr and manual_data_in unchanged during HOLD.
REQ-021 SHALL: HOLD exit: addr<15 -> manual_addr+1, -> WAIT_BYTE; addr=15 -> manual_addr wraps to 0, -> CHECK (macro set) or DONE.
REQ-022 SHALL: per-byte minimum throughput 4 cycles (accept, SETUP, STROBE, HOLD); rx_valid low stalls in WAIT_BYTE indefinitely.
REQ-023 SHALL: DONE: done=1 one cycle, program=0 on same cycle, -> IDLE.
REQ-024 SHALL: program=1 continuously from start-accept cycle until DONE or abort; never toggles mid-session.
REQ-025 SHALL: abort=1 in any non-IDLE state -> IDLE next edge: program=0, manual_clk=0, rx_ready=0, no done; abort beats rx transfer in the same cycle; abort ignored in IDLE.
REQ-026 SHALL: start while busy ignored; start and abort both high in IDLE -> stay IDLE.
REQ-027 SHALL: exactly 16 strobes per completed session, addresses 0..15 ascending, one strobe per accepted byte.

Reset
REQ-028 SHALL: clr=0 asynchronously forces IDLE, program=0, manual_addr=0, manual_data_in=0x00, manual_clk=0, rx_ready=0, busy=0, done=0, error=0, checksum accumulator=0.
REQ-029 SHALL: reset mid-session abandons the session; RAM contents already written remain; after release loader waits for a fresh start.

Configuration
REQ-030 SHALL: macro LOADER_CHECKSUM_EN defined: 8-bit accumulator sums the 16 data bytes mod 256; CHECK state rx_ready=1 accepts a 17th byte (no strobe); mismatch sets error=1 (sticky until next start accept or reset), then DONE; done pulses regardless of error.
REQ-031 SHALL: macro undefined: no CHECK state, no accumulator, HOLD at addr 15 -> DONE directly, error tied 0.

Verification
REQ-032 SHALL: start, bytes 0x10..0x1F back-to-back -> 16 strobes, addr 0..15 with data 0x10..0x1F, done at session end, 64 cycles accept-to-DONE, program low after.
REQ-033 SHALL: rx_valid deasserted 10 cycles before byte 5 -> rx_ready held high, no strobe, manual_addr=4 stable, session then completes normally.
REQ-034 SHALL: abort during STROBE of addr 7 -> next cycle IDLE, program=0, manual_clk=0, no done; new start restarts at addr 0.
REQ-035 SHALL: clr low in HOLD of addr 3 -> all outputs at reset values immediately; start ignored while clr low.
REQ-036 SHALL: LOADER_CHECKSUM_EN: 16 bytes 0x01 then 0x10 -> error=0, done; then 16 bytes 0x01 then 0x11 -> error=1, done; next start clears error.
REQ-037 SHALL: start asserted during a session and start+abort in IDLE -> no state change, busy unaffected.

Source files
------------

// File: rtl/ram_loader.sv
// ram_loader: streams 16 rx bytes into RAM addresses 0..15 via registered strobes.
// LOADER_CHECKSUM_EN adds a trailing checksum byte; the RAM select port is prog.
module ram_loader (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       prog,
  output logic [3:0] manual_addr,
  output logic [7:0] manual_data_in,
  output logic       manual_clk,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BYTE,
    SETUP,
    STROBE,
    HOLD,
`ifdef LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       rdy_q, rdy_d;
  logic       prog_q, prog_d;
  logic       mclk_q, mclk_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif
    // abort wins over any handshake in the same cycle
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_d = WAIT_BYTE;
            addr_d  = 4'd0;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = 8'd0;
            err_d   = 1'b0;
`endif
          end
        end
        WAIT_BYTE: begin
          if (rx_valid) begin
            data_d  = rx_data;
            state_d = SETUP;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = sum_q + rx_data;
`endif
          end
        end
        SETUP:  state_d = STROBE;
        STROBE: state_d = HOLD;
        HOLD: begin
          addr_d = addr_q + 4'd1;
          if (addr_q == 4'd15) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = WAIT_BYTE;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (rx_valid) begin
            err_d   = (rx_data != sum_q);
            state_d = DONE;
          end
        end
`endif
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    rdy_d  = (state_d == WAIT_BYTE);
`ifdef LOADER_CHECKSUM_EN
    rdy_d  = rdy_d || (state_d == CHECK);
`endif
    prog_d = (state_d != IDLE) && (state_d != DONE);
    mclk_d = (state_d == STROBE);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      addr_q  <= 4'd0;
      data_q  <= 8'd0;
      rdy_q   <= 1'b0;
      prog_q  <= 1'b0;
      mclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      prog_q  <= prog_d;
      mclk_q  <= mclk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

  assign rx_ready       = rdy_q;
  assign prog           = prog_q;
  assign manual_addr    = addr_q;
  assign manual_data_in = data_q;
  assign manual_clk     = mclk_q;
  assign busy           = busy_q;
  assign done           = done_q;
`ifdef LOADER_CHECKSUM_EN
  assign error          = err_q;
`else
  assign error          = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: scoreboard bench for ram_loader strobes, handshakes and session control.
// Build with LOADER_CHECKSUM_EN to cover the checksum byte as well.
`timescale 1ns/1ps
module tb_ram_loader;

  logic       clk = 1'b0;
  logic       clr, start, abort, rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready, prog, manual_clk, busy, done, error;
  logic [3:0] manual_addr;
  logic [7:0] manual_data_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  logic        mclk_prev = 1'b0;
  logic        done_prev = 1'b0;
  logic [11:0] exp_q[$];
  logic [11:0] last_e = '0;

`ifdef LOADER_CHECKSUM_EN
  localparam int LAT = 65;
`else
  localparam int LAT = 64;
`endif

  ram_loader dut (
    .clk            (clk),
    .clr            (clr),
    .start          (start),
    .abort          (abort),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .prog           (prog),
    .manual_addr    (manual_addr),
    .manual_data_in (manual_data_in),
    .manual_clk     (manual_clk),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // strobe/done monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (clr) begin
      if (manual_clk && !mclk_prev) begin
        strobe_cnt++;
        check("strobe_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          last_e = exp_q.pop_front();
          check("strobe_addr", manual_addr, last_e[11:8]);
          check("strobe_data", manual_data_in, last_e[7:0]);
          check("strobe_prog", prog, 1);
        end
      end
      if (!manual_clk && mclk_prev) begin
        check("hold_addr", manual_addr, last_e[11:8]);
        check("hold_data", manual_data_in, last_e[7:0]);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_prog_low", prog, 0);
        check("done_single", done_prev, 0);
      end
    end
    mclk_prev = manual_clk;
    done_prev = done;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_session();
    start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;
    check("start_busy", busy, 1);
    check("start_prog", prog, 1);
    check("start_addr", manual_addr, 0);
    check("start_rdy", rx_ready, 1);
    check("start_err", error, 0);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic [3:0] a,
                           input logic push);
    int n = 0;
    rx_data  = d;
    rx_valid = 1'b1;
    while (!rx_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("rx_ready_wait", rx_ready, 1);
    if (rx_ready) begin
      if (push) exp_q.push_back({a, d});
      tick();
      if (push) check("latch_data", manual_data_in, d);
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int n = 0;
    while (done_cnt == base && n < 20) begin
      tick();
      n++;
    end
    check("done_seen", done_cnt, base + 1);
  endtask

  task automatic run_session(input logic [7:0] base, input logic [7:0] step,
                             input logic [7:0] ck, input logic exp_err);
    int s0 = strobe_cnt;
    int d0 = done_cnt;
    start_session();
    for (int i = 0; i < 16; i++)
      send_byte(base + 8'(i) * step, 4'(i), 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(ck, 4'd0, 1'b0);
`endif
    wait_done(d0);
    check("latency", done_cyc - start_cyc, LAT);
    check("strobes", strobe_cnt - s0, 16);
    check("prog_after", prog, 0);
    check("busy_after", busy, 0);
    check("error_after", error, exp_err);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int d0;
    clr = 1'b0; start = 1'b0; abort = 1'b0;
    rx_valid = 1'b0; rx_data = 8'h00;
    #1;
    check("rst_rdy", rx_ready, 0);
    check("rst_prog", prog, 0);
    check("rst_addr", manual_addr, 0);
    check("rst_data", manual_data_in, 0);
    check("rst_mclk", manual_clk, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", error, 0);
    tick(2);
    clr = 1'b1;
    tick(2);

    // back-to-back session
    run_session(8'h10, 8'h01, 8'h78, 1'b0);

    // start+abort and abort alone in idle
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("idle_sa_busy", busy, 0);
    check("idle_sa_prog", prog, 0);
    check("idle_sa_rdy", rx_ready, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_busy", busy, 0);

    // stall before byte 5, start ignored mid-session
    d0 = done_cnt;
    s0 = strobe_cnt;
    start_session();
    for (int i = 0; i < 4; i++) send_byte(8'h80 + 8'(i), 4'(i), 1'b1);
    tick(3);
    for (int k = 0; k < 10; k++) begin
      check("stall_rdy", rx_ready, 1);
      check("stall_addr", manual_addr, 4);
      tick();
    end
    check("stall_strobes", strobe_cnt - s0, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("mid_start_busy", busy, 1);
    check("mid_start_addr", manual_addr, 4);
    check("mid_start_rdy", rx_ready, 1);
    for (int i = 4; i < 16; i++) send_byte(8'h80 + 8'(i), 4'(i), 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h78, 4'd0, 1'b0);
`endif
    wait_done(d0);
    check("stall_total", strobe_cnt - s0, 16);
    check("stall_prog", prog, 0);

    // abort during strobe of addr 7
    d0 = done_cnt;
    start_session();
    for (int i = 0; i < 8; i++) send_byte(8'h40 + 8'(i), 4'(i), 1'b1);
    tick();
    check("abort_in_strobe", manual_clk, 1);
    check("abort_addr", manual_addr, 7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_prog", prog, 0);
    check("abort_mclk", manual_clk, 0);
    check("abort_busy", busy, 0);
    check("abort_rdy", rx_ready, 0);
    tick(5);
    check("abort_no_done", done_cnt, d0);
    check("abort_queue", exp_q.size(), 0);
    run_session(8'h30, 8'h01, 8'h78, 1'b0);

    // reset in hold of addr 3
    start_session();
    for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i), 4'(i), 1'b1);
    tick(2);
    check("hold3_mclk", manual_clk, 0);
    check("hold3_addr", manual_addr, 3);
    #2 clr = 1'b0;
    #1;
    check("clr_rdy", rx_ready, 0);
    check("clr_prog", prog, 0);
    check("clr_addr", manual_addr, 0);
    check("clr_data", manual_data_in, 0);
    check("clr_mclk", manual_clk, 0);
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    start = 1'b1;
    tick(3);
    check("clr_start_busy", busy, 0);
    check("clr_start_prog", prog, 0);
    start = 1'b0;
    #2 clr = 1'b1;
    tick();
    check("post_clr_busy", busy, 0);
    check("post_clr_queue", exp_q.size(), 0);
    run_session(8'h10, 8'h01, 8'h78, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    run_session(8'h01, 8'h00, 8'h10, 1'b0);
    run_session(8'h01, 8'h00, 8'h11, 1'b1);
    start_session();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("err_cleared_idle", error, 0);
`endif

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
